// File: rtl/alu_issue.sv
// RV32I execute-stage issue unit: decodes instruction + operands into ALU controls behind a valid/ready register.
// Define ALU_ISSUE_SKID_EN for a two-entry (main + skid) buffer with registered in_ready and full throughput.
module alu_issue #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [31:0]     pc,
    input  logic [31:0]     rs1_data,
    input  logic [31:0]     rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            illegal
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_ILL  = 4'b1111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
    } issue_t;

    // Pure decode of one instruction into the ALU control bundle; shift amounts are zero-extended to 5 bits.
    function automatic issue_t decode_op(input logic [31:0] ins, input logic [31:0] pc_v,
                                         input logic [31:0] r1, input logic [31:0] r2);
        issue_t      e;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_u;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        legal;
        logic        wr;
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_u = {ins[31:12], 12'h000};
        e.ctrl = ALU_ADD;
        e.a    = r1;
        e.b    = imm_i;
        e.rd   = ins[11:7];
        e.wr   = 1'b0;
        e.ill  = 1'b0;
        legal  = 1'b1;
        wr     = 1'b1;
        case (ins[6:0])
            OPC_OP: begin
                e.b = r2;
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  e.ctrl = ALU_ADD;
                        3'b001:  begin e.ctrl = ALU_SLL; e.b = {27'd0, r2[4:0]}; end
                        3'b010:  e.ctrl = ALU_SLT;
                        3'b011:  e.ctrl = ALU_SLTU;
                        3'b100:  e.ctrl = ALU_XOR;
                        3'b101:  begin e.ctrl = ALU_SRL; e.b = {27'd0, r2[4:0]}; end
                        3'b110:  e.ctrl = ALU_OR;
                        3'b111:  e.ctrl = ALU_AND;
                        default: legal = 1'b0;
                    endcase
                end else if (f7 == F7_ALT) begin
                    case (f3)
                        3'b000:  e.ctrl = ALU_SUB;
                        3'b101:  begin e.ctrl = ALU_SRA; e.b = {27'd0, r2[4:0]}; end
                        default: legal = 1'b0;
                    endcase
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                case (f3)
                    3'b000:  e.ctrl = ALU_ADD;
                    3'b010:  e.ctrl = ALU_SLT;
                    3'b011:  e.ctrl = ALU_SLTU;
                    3'b100:  e.ctrl = ALU_XOR;
                    3'b110:  e.ctrl = ALU_OR;
                    3'b111:  e.ctrl = ALU_AND;
                    3'b001: begin
                        e.ctrl = ALU_SLL;
                        e.b    = {27'd0, ins[24:20]};
                        legal  = (f7 == F7_BASE);
                    end
                    3'b101: begin
                        e.b = {27'd0, ins[24:20]};
                        if (f7 == F7_BASE) begin
                            e.ctrl = ALU_SRL;
                        end else if (f7 == F7_ALT) begin
                            e.ctrl = ALU_SRA;
                        end else begin
                            legal = 1'b0;
                        end
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI:   begin e.a = 32'd0; e.b = imm_u; end
            OPC_AUIPC: begin e.a = pc_v;  e.b = imm_u; end
            OPC_LOAD:  e.b = imm_i;
            OPC_STORE: begin e.b = imm_s; wr = 1'b0; end
            OPC_BRANCH: begin
                e.b = r2;
                wr  = 1'b0;
                case (f3)
                    3'b000, 3'b001: e.ctrl = ALU_SUB;
                    3'b100, 3'b101: e.ctrl = ALU_SLT;
                    3'b110, 3'b111: e.ctrl = ALU_SLTU;
                    default:        legal = 1'b0;
                endcase
            end
            OPC_JAL, OPC_JALR: begin e.a = pc_v; e.b = 32'd4; end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e.ctrl = ALU_ILL;
            e.a    = 32'd0;
            e.b    = 32'd0;
        end else begin
            e.ctrl = e.ctrl;
        end
        e.ill = ~legal;
        e.wr  = wr & legal & (ins[11:7] != 5'd0);
        return e;
    endfunction

    issue_t dec_s;
    logic   in_fire_s;
    logic   out_fire_s;
    logic   unused_s;

    assign dec_s    = decode_op(instr, pc, rs1_data, rs2_data);
    assign unused_s = ^instr[19:15];

    issue_t main_q, main_d;
    logic   main_vld_q, main_vld_d;

`ifdef ALU_ISSUE_SKID_EN
    issue_t skid_q, skid_d;
    logic   skid_vld_q, skid_vld_d;
    logic   in_rdy_q, in_rdy_d;

    assign in_ready   = in_rdy_q;
    assign in_fire_s  = in_valid & in_rdy_q & ~flush;
    assign out_fire_s = main_vld_q & out_ready;

    // Next-state for the main/skid pair; the skid only fills while main is stalled.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q) begin
            if (in_fire_s) begin
                main_d     = dec_s;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (out_fire_s) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = in_fire_s;
                if (in_fire_s) begin
                    skid_d = dec_s;
                end else begin
                    skid_d = skid_q;
                end
            end else begin
                main_vld_d = in_fire_s;
                if (in_fire_s) begin
                    main_d = dec_s;
                end else begin
                    main_d = main_q;
                end
            end
        end else begin
            if (in_fire_s) begin
                skid_d     = dec_s;
                skid_vld_d = 1'b1;
            end else begin
                skid_vld_d = skid_vld_q;
            end
        end
        in_rdy_d = ~skid_vld_d;
    end

    // Skid entry and registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            in_rdy_q   <= 1'b1;
        end else begin
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            in_rdy_q   <= in_rdy_d;
        end
    end
`else
    assign in_ready   = ~main_vld_q | out_ready;
    assign in_fire_s  = in_valid & in_ready & ~flush;
    assign out_fire_s = main_vld_q & out_ready;

    // Next-state for the single output register.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
        end else if (in_fire_s) begin
            main_d     = dec_s;
            main_vld_d = 1'b1;
        end else if (out_fire_s) begin
            main_vld_d = 1'b0;
        end else begin
            main_vld_d = main_vld_q;
        end
    end
`endif

    // Main output register; its contents drive every ALU-facing output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
        end
    end

    assign out_valid   = main_vld_q;
    assign alu_control = main_q.ctrl;
    assign alu_a       = main_q.a;
    assign alu_b       = main_q.b;
    assign rd          = main_q.rd;
    assign reg_write   = main_q.wr;
    assign illegal     = main_q.ill;

endmodule
